// File: rtl/fetch_if.sv
// Fetch-stage bus bundle: instruction-memory read port plus the IF/ID register view toward decode.
interface fetch_if #(
  parameter int ADDR_W = 7
);
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_data;
  logic              stall;
  logic              branch_taken;
  logic [15:0]       branch_imm;
  logic [31:0]       id_instr;
  logic [ADDR_W-1:0] id_pc;
  logic              id_valid;
  logic [ADDR_W-1:0] pc_out;

  modport master (
    output imem_addr, id_instr, id_pc, id_valid, pc_out,
    input  imem_data, stall, branch_taken, branch_imm
  );

  modport slave (
    input  imem_addr, id_instr, id_pc, id_valid, pc_out,
    output imem_data, stall, branch_taken, branch_imm
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads instruction memory and fills the IF/ID register,
// handling decode stalls and taken-branch redirects (one bubble per redirect).
module fetch_unit #(
  parameter int                ADDR_W   = 7,
  parameter logic [ADDR_W-1:0] START_PC = {ADDR_W{1'b0}},
  parameter logic [31:0]       NOP_WORD = 32'h0000_0000
) (
  input  logic     clk,
  input  logic     rst_n,
  fetch_if.master  bus
);

  typedef enum logic [1:0] {
    S_FILL     = 2'd0,
    S_RUN      = 2'd1,
    S_STALL    = 2'd2,
    S_REDIRECT = 2'd3
  } state_t;

  localparam int OFF_W = (ADDR_W > 18) ? ADDR_W : 18;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       id_instr_q, id_instr_d;
  logic [ADDR_W-1:0] id_pc_q, id_pc_d;
  logic              id_valid_q, id_valid_d;

  logic              branch_ok_s;
  logic [17:0]       off18_s;
  logic [ADDR_W-1:0] target_s;

  // A branch is only meaningful for a real instruction in IF/ID; bubbles cannot branch.
  assign branch_ok_s = bus.branch_taken & id_valid_q;
  assign off18_s     = {bus.branch_imm, 2'b00};
  assign target_s    = ADDR_W'(OFF_W'(id_pc_q) + OFF_W'(3'd4) + OFF_W'(signed'(off18_s)));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: branch beats stall beats normal flow
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FILL: begin
        state_d = S_RUN;
      end
      S_RUN, S_STALL, S_REDIRECT: begin
        if (branch_ok_s) begin
          state_d = S_REDIRECT;
        end else if (bus.stall) begin
          state_d = S_STALL;
        end else begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_FILL;
      end
    endcase
  end

  // Datapath next values for PC and IF/ID
  always_comb begin
    pc_d       = pc_q;
    id_instr_d = id_instr_q;
    id_pc_d    = id_pc_q;
    id_valid_d = id_valid_q;
    case (state_q)
      S_FILL: begin
        pc_d = pc_q;
      end
      S_RUN, S_STALL, S_REDIRECT: begin
        if (branch_ok_s) begin
          pc_d       = target_s;
          id_instr_d = NOP_WORD;
          id_valid_d = 1'b0;
        end else if (bus.stall) begin
          pc_d = pc_q;
        end else begin
          id_instr_d = bus.imem_data;
          id_pc_d    = pc_q;
          id_valid_d = 1'b1;
          pc_d       = pc_q + ADDR_W'(3'd4);
        end
      end
      default: begin
        pc_d = pc_q;
      end
    endcase
  end

  // PC and IF/ID registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= START_PC;
      id_instr_q <= NOP_WORD;
      id_pc_q    <= {ADDR_W{1'b0}};
      id_valid_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      id_instr_q <= id_instr_d;
      id_pc_q    <= id_pc_d;
      id_valid_q <= id_valid_d;
    end
  end

  assign bus.imem_addr = pc_q;
  assign bus.pc_out    = pc_q;
  assign bus.id_instr  = id_instr_q;
  assign bus.id_pc     = id_pc_q;
  assign bus.id_valid  = id_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a cycle-level reference model pushes expected state,
// a monitor pops and compares after every posedge.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  fetch_if #(.ADDR_W(7)) bus ();

  fetch_unit #(.ADDR_W(7), .START_PC(7'd0), .NOP_WORD(32'h0000_0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  pc;
    logic [6:0]  ipc;
    logic        iv;
    logic [31:0] ii;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [31:0] mem [0:31];
  int          checks   = 0;
  int          failures = 0;

  int          m_pc, m_ipc;
  bit          m_iv, m_fill;
  logic [31:0] m_ii;

  // Instruction memory samples the address on the falling edge
  always @(negedge clk) bus.imem_data = mem[bus.imem_addr[6:2]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        chk("pc_out",    {25'd0, bus.pc_out},    {25'd0, mon_e.pc});
        chk("imem_addr", {25'd0, bus.imem_addr}, {25'd0, mon_e.pc});
        chk("id_valid",  {31'd0, bus.id_valid},  {31'd0, mon_e.iv});
        chk("id_pc",     {25'd0, bus.id_pc},     {25'd0, mon_e.ipc});
        chk("id_instr",  bus.id_instr,           mon_e.ii);
      end
    end
  end

  task automatic model_reset();
    m_pc   = 0;
    m_ipc  = 0;
    m_iv   = 1'b0;
    m_ii   = NOP;
    m_fill = 1'b1;
  endtask

  task automatic step(input bit s, input bit b, input logic [15:0] imm);
    exp_t e;
    @(negedge clk);
    bus.stall        = s;
    bus.branch_taken = b;
    bus.branch_imm   = imm;
    if (m_fill) begin
      m_fill = 1'b0;
    end else if (b && m_iv) begin
      m_pc = (m_ipc + 4 + 4 * int'($signed(imm))) & 127;
      m_ii = NOP;
      m_iv = 1'b0;
    end else if (!s) begin
      m_ii  = mem[m_pc / 4];
      m_ipc = m_pc;
      m_iv  = 1'b1;
      m_pc  = (m_pc + 4) % 128;
    end
    e.pc  = m_pc[6:0];
    e.ipc = m_ipc[6:0];
    e.iv  = m_iv;
    e.ii  = m_ii;
    sb_q.push_back(e);
    @(posedge clk);
  endtask

  task automatic run_to(input int target_ipc);
    for (int k = 0; k < 64 && !(m_iv && m_ipc == target_ipc); k++) step(1'b0, 1'b0, 16'h0000);
  endtask

  // Called just after a posedge: reset falls between edges and outputs are checked at once
  task automatic do_reset();
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_pc",       {25'd0, bus.pc_out},    32'd0);
    chk("rst_addr",     {25'd0, bus.imem_addr}, 32'd0);
    chk("rst_id_valid", {31'd0, bus.id_valid},  32'd0);
    chk("rst_id_instr", bus.id_instr,           NOP);
    chk("rst_id_pc",    {25'd0, bus.id_pc},     32'd0);
    sb_q.delete();
    model_reset();
    bus.stall        = 1'b0;
    bus.branch_taken = 1'b0;
    bus.branch_imm   = 16'h0000;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    bus.stall        = 1'b0;
    bus.branch_taken = 1'b0;
    bus.branch_imm   = 16'h0000;
    model_reset();
    do_reset();

    // Fill, then sequential fetch; stray stall/branch during FILL must be ignored
    step(1'b1, 1'b1, 16'h0004);
    repeat (3) step(1'b0, 1'b0, 16'h0000);

    // Stall with id_pc=8
    run_to(8);
    repeat (3) step(1'b1, 1'b0, 16'h0000);
    step(1'b0, 1'b0, 16'h0000);

    // Branch from 40 back to 12, then same with simultaneous stall
    run_to(40);
    step(1'b0, 1'b1, 16'hFFF8);
    repeat (2) step(1'b0, 1'b0, 16'h0000);
    run_to(40);
    step(1'b1, 1'b1, 16'hFFF8);
    step(1'b0, 1'b1, 16'h0010);
    step(1'b0, 1'b0, 16'h0000);

    // Wrap past 124
    repeat (40) step(1'b0, 1'b0, 16'h0000);

    // Reset in the middle of a redirect
    run_to(40);
    step(1'b0, 1'b1, 16'hFFF8);
    do_reset();
    repeat (4) step(1'b0, 1'b0, 16'h0000);

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0), 16'($urandom));
    end
    step(1'b0, 1'b0, 16'h0000);
    @(posedge clk);
    #2;
    chk("sb_drained", sb_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
